pci_bus_arbiter: RTL and testbench
==================================

Name: pci_bus_arbiter

Overview:
Central PCI arbiter that shares the bus among up to NUM_MASTERS Controller instances. It samples each device's active-low req and drives the matching active-low gnt. It tracks bus ownership by watching frame and irdy. Arbitration is rotating-priority with a grant-timeout and a guaranteed dead cycle between owners, so two gnt lines are never low together.

Parameters:
NUM_MASTERS, 4, number of requesting devices (2..8)
GNT_TIMEOUT, 16, idle-bus cycles a granted master may leave unused before revocation (>=2)
PARK_MASTER, 0, index parked on when PCI_ARB_PARK_EN is defined

Ports:
clk  in  1  bus clock, rising edge
reset  in  1  synchronous, active-high
req  in  NUM_MASTERS  per-master request, active-low
frame  in  1  bus FRAME, active-low
irdy  in  1  bus IRDY, active-low
gnt  out  NUM_MASTERS  per-master grant, active-low, registered
owner  out  $clog2(NUM_MASTERS)  index of current/last granted master
owner_valid  out  1  high while any gnt bit is low
arb_state  out  3  current FSM state (debug)

Behaviour:
- Reset, synchronous and active-high: state=IDLE, gnt=all 1, owner=0, owner_valid=0, rr pointer=0, timeout counter=0. Takes effect on the next edge from any state, including BUSY.
- bus_idle = frame & irdy, both deasserted.
- Winner selection: the first req bit low, searching from the rr pointer upward with wrap. The pointer updates to (winner+1) mod NUM_MASTERS on entry to DEAD.
- IDLE: all gnt high.
  - If any req is low, go to GRANT. gnt[winner] is low from the next cycle, so latency is 1 edge.
- GRANT: gnt[w] low.
  - frame low: go to BUSY, counter cleared.
  - req[w] high: go to DEAD.
  - Counter increments only while bus_idle. When it reaches GNT_TIMEOUT-1: go to DEAD (revoke).
  - frame low has priority over the other exits in the same cycle.
- BUSY: master w owns the bus.
  - If any other req is low, drive gnt[w] high on the next edge (preemption). State stays BUSY; w finishes its transaction under its own latency timer.
  - On bus_idle: if gnt[w] is still low, req[w] is low and no other req is low, go to GRANT (back-to-back, counter cleared). Otherwise go to DEAD.
- DEAD: all gnt high for exactly one cycle.
  - Any req low: go to GRANT with a new winner.
  - No req low: go to IDLE.
- Invariant: at most one gnt bit low in any cycle.
- Ownership handover always includes at least one all-high gnt cycle.
- owner updates when a gnt goes low and holds its value otherwise.
- req changes while in DEAD are honoured the same cycle.
- A req pulse shorter than 1 cycle that is missed is not latched.

Optional Feature:
PCI_ARB_PARK_EN
- Defined: IDLE is replaced by PARK. gnt[PARK_MASTER] is low when no req is low, and owner_valid=1.
  - In PARK, req[PARK_MASTER] low with no other req low: go to GRANT without a dead cycle.
  - Any other req low: go to DEAD.
  - frame low while parked: go to BUSY with w=PARK_MASTER.
- Undefined: no parking; the behaviour is as above.

Decomposition:
- Package pci_arb_pkg holds:
  - the state enum: IDLE=0, GRANT=1, BUSY=2, DEAD=3, PARK=4
  - the default GNT_TIMEOUT
  - a function for the index width
- Sub-module pci_rr_picker: combinational rotate/find-first/rotate-back. Inputs are req and the pointer; outputs are the winner index and any_req. It is reused by the FSM.

Test Plan:
- Assert reset mid-stream, then deassert -> gnt=4'b1111, owner_valid=0, arb_state=IDLE next edge.
- req=4'b1110 -> gnt=4'b1110 one edge later; frame low -> BUSY; release req and frame/irdy -> DEAD gnt=4'b1111, then IDLE.
- req=4'b0000 held, each master doing one 3-cycle transaction -> grants in order 0,1,2,3,0; each handover has at least one gnt=4'b1111 cycle; never two gnt bits low.
- Master 1 granted, frame stays high for 16 idle cycles, req=4'b1001 -> gnt[1] high after cycle 16; gnt=4'b1011 after the dead cycle.
- Master 0 BUSY, req[2] goes low -> gnt[0] high next edge; gnt[2] low only after bus_idle plus 1 dead cycle.
- With PCI_ARB_PARK_EN and req=4'b1111 -> gnt=4'b1110 parked; req[3] low -> gnt=4'b1111 for 1 cycle, then 4'b0111.

Source files
------------

// File: rtl/pci_arb_pkg.sv
// Shared types and helpers for the PCI bus arbiter.
package pci_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    BUSY  = 3'd2,
    DEAD  = 3'd3,
    PARK  = 3'd4
  } arb_state_e;

  localparam int DEF_GNT_TIMEOUT = 16;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// Rotating-priority picker: first set request at or above ptr, wrapping past N-1.
module pci_rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] win_o,
  output logic          any_o
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot_n;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  logic           found;

  always_comb begin
    dbl   = {req_i, req_i};
    rot_n = N'(dbl >> ptr_i);
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot_n[i]) begin
        off   = i[IW-1:0];
        found = 1'b1;
      end
    end
    // Rotate back: ptr + offset, folded into 0..N-1.
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    win_o = sum[IW-1:0];
    any_o = |req_i;
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: rotating priority, grant timeout, one dead cycle between owners.
// Optional bus parking on PARK_MASTER when PCI_ARB_PARK_EN is defined.
module pci_bus_arbiter
  import pci_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT,
  parameter int PARK_MASTER = 0,
  localparam int IW = idx_w(NUM_MASTERS)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic                   frame_i,
  input  logic                   irdy_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IW-1:0]          owner_o,
  output logic                   owner_valid_o,
  output logic [2:0]             arb_state_o
);

  localparam int CW = (GNT_TIMEOUT <= 2) ? 1 : $clog2(GNT_TIMEOUT);

`ifdef PCI_ARB_PARK_EN
  localparam logic [IW-1:0]          PARK_IDX  = IW'(PARK_MASTER);
  localparam logic [NUM_MASTERS-1:0] PARK_MASK = NUM_MASTERS'(1) << PARK_MASTER;
`endif

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IW-1:0]          owner_q, rr_q, w_q;
  logic [CW-1:0]          cnt_q;

  logic [NUM_MASTERS-1:0] reqv, w_mask, win_mask;
  logic [IW-1:0]          win, rr_next;
  logic                   any_req, others_any, bus_idle;

  assign reqv       = ~req_i;
  assign bus_idle   = frame_i & irdy_i;
  assign w_mask     = NUM_MASTERS'(1) << w_q;
  assign win_mask   = NUM_MASTERS'(1) << win;
  assign others_any = |(reqv & ~w_mask);
  assign rr_next    = (w_q == IW'(NUM_MASTERS-1)) ? '0 : w_q + IW'(1);

  pci_rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req_i (reqv),
    .ptr_i (rr_q),
    .win_o (win),
    .any_o (any_req)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      gnt_q   <= '1;
      owner_q <= '0;
      rr_q    <= '0;
      w_q     <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DEAD: begin
          if (any_req) begin
            state_q <= GRANT;
            gnt_q   <= ~win_mask;
            owner_q <= win;
            w_q     <= win;
            cnt_q   <= '0;
          end else begin
`ifdef PCI_ARB_PARK_EN
            state_q <= PARK;
            gnt_q   <= ~PARK_MASK;
            owner_q <= PARK_IDX;
            w_q     <= PARK_IDX;
`else
            state_q <= IDLE;
            gnt_q   <= '1;
`endif
          end
        end
        GRANT: begin
          // A started transaction wins over release or timeout in the same cycle.
          if (!frame_i) begin
            state_q <= BUSY;
            cnt_q   <= '0;
          end else if (!reqv[w_q] || (bus_idle && cnt_q == CW'(GNT_TIMEOUT-1))) begin
            state_q <= DEAD;
            gnt_q   <= '1;
            rr_q    <= rr_next;
          end else if (bus_idle) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        BUSY: begin
          if (bus_idle) begin
            if (!gnt_q[w_q] && reqv[w_q] && !others_any) begin
              state_q <= GRANT;
              cnt_q   <= '0;
            end else begin
              state_q <= DEAD;
              gnt_q   <= '1;
              rr_q    <= rr_next;
            end
          end else if (others_any) begin
            // Preempt: owner completes under its own latency timer.
            gnt_q <= '1;
          end
        end
`ifdef PCI_ARB_PARK_EN
        PARK: begin
          if (!frame_i) begin
            state_q <= BUSY;
            cnt_q   <= '0;
          end else if (reqv == PARK_MASK) begin
            state_q <= GRANT;
            cnt_q   <= '0;
          end else if (any_req) begin
            state_q <= DEAD;
            gnt_q   <= '1;
            rr_q    <= rr_next;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          gnt_q   <= '1;
        end
      endcase
    end
  end

  assign gnt_o         = gnt_q;
  assign owner_o       = owner_q;
  assign owner_valid_o = ~&gnt_q;
  assign arb_state_o   = state_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (default build, 4 masters, timeout 16).
module tb_pci_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       frame, irdy;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       owner_valid;
  logic [2:0] arb_state;

  int n_chk  = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;

  localparam logic [2:0] S_IDLE = 3'd0, S_GRANT = 3'd1, S_BUSY = 3'd2, S_DEAD = 3'd3;

  pci_bus_arbiter #(.NUM_MASTERS(4), .GNT_TIMEOUT(16), .PARK_MASTER(0)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_i         (req),
    .frame_i       (frame),
    .irdy_i        (irdy),
    .gnt_o         (gnt),
    .owner_o       (owner),
    .owner_valid_o (owner_valid),
    .arb_state_o   (arb_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // At most one grant low in every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      n_chk++;
      assert ($onehot0(~gnt)) else begin
        n_fail++;
        $error("FAIL onehot_gnt: observed %b expected at most one low", gnt);
      end
    end
  end

  initial begin
    logic [3:0] eg;
    reset = 1'b1; req = 4'b1111; frame = 1'b1; irdy = 1'b1;
    tick();
    chk("rst_gnt",   gnt, 4'b1111);
    chk("rst_ov",    owner_valid, 1'b0);
    chk("rst_state", arb_state, S_IDLE);
    chk("rst_owner", owner, 2'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Single grant, transaction, release.
    req = 4'b1110; tick();
    chk("g0_state", arb_state, S_GRANT);
    chk("g0_gnt",   gnt, 4'b1110);
    chk("g0_ov",    owner_valid, 1'b1);
    frame = 1'b0; tick();
    chk("g0_busy", arb_state, S_BUSY);
    irdy = 1'b0; req = 4'b1111; tick();
    chk("g0_busy_hold", gnt, 4'b1110);
    frame = 1'b1; irdy = 1'b1; tick();
    chk("g0_dead_state", arb_state, S_DEAD);
    chk("g0_dead_gnt",   gnt, 4'b1111);
    tick();
    chk("g0_idle",   arb_state, S_IDLE);
    chk("g0_idle_ov", owner_valid, 1'b0);

    // Reset while BUSY (pointer is 1 here, so master 1 wins).
    req = 4'b1101; tick();
    chk("r_gnt",   gnt, 4'b1101);
    chk("r_owner", owner, 2'd1);
    frame = 1'b0; tick();
    chk("r_busy", arb_state, S_BUSY);
    reset = 1'b1; tick();
    chk("r_state", arb_state, S_IDLE);
    chk("r_gntF",  gnt, 4'b1111);
    chk("r_owner0", owner, 2'd0);
    chk("r_ov",    owner_valid, 1'b0);
    reset = 1'b0; frame = 1'b1; req = 4'b1111; tick();
    chk("r_after", arb_state, S_IDLE);

    // Everyone requesting: rotation 0,1,2,3,0 with a dead cycle at each handover.
    req = 4'b0000; tick();
    for (int k = 0; k < 4; k++) begin
      eg = ~(4'b0001 << k);
      chk("rr_gnt",   gnt, eg);
      chk("rr_owner", owner, k);
      frame = 1'b0; irdy = 1'b1; tick();
      chk("rr_busy", arb_state, S_BUSY);
      irdy = 1'b0; tick();
      chk("rr_preempt", gnt, 4'b1111);
      chk("rr_owner_hold", owner, k);
      frame = 1'b1; tick();
      chk("rr_busy_last", arb_state, S_BUSY);
      irdy = 1'b1; tick();
      chk("rr_dead", arb_state, S_DEAD);
      chk("rr_dead_gnt", gnt, 4'b1111);
      tick();
    end
    chk("rr_wrap_gnt", gnt, 4'b1110);
    chk("rr_wrap_owner", owner, 2'd0);
    req = 4'b1111; tick();
    chk("rr_rel_dead", arb_state, S_DEAD);
    tick();
    chk("rr_rel_idle", arb_state, S_IDLE);

    // Timeout: pointer is 1, master 1 granted and never starts.
    req = 4'b1001;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("to_hold", gnt, 4'b1101);
    end
    tick();
    chk("to_revoke", gnt, 4'b1111);
    chk("to_dead", arb_state, S_DEAD);
    tick();
    chk("to_next", gnt, 4'b1011);
    chk("to_owner", owner, 2'd2);
    req = 4'b1111; tick();
    chk("to_rel", arb_state, S_DEAD);
    tick();

    // Preemption: pointer is 3, master 0 wins then master 2 asks.
    req = 4'b1110; tick();
    chk("pe_gnt", gnt, 4'b1110);
    frame = 1'b0; tick();
    chk("pe_busy", arb_state, S_BUSY);
    req = 4'b1010; tick();
    chk("pe_revoke", gnt, 4'b1111);
    chk("pe_state", arb_state, S_BUSY);
    tick();
    chk("pe_wait", gnt, 4'b1111);
    frame = 1'b1; irdy = 1'b1; tick();
    chk("pe_dead", arb_state, S_DEAD);
    chk("pe_dead_gnt", gnt, 4'b1111);
    tick();
    chk("pe_new", gnt, 4'b1011);
    chk("pe_owner", owner, 2'd2);
    req = 4'b1111; tick(); tick();
    chk("pe_idle", arb_state, S_IDLE);

    // Back-to-back: sole requester keeps the bus without a dead cycle (pointer 3 -> master 0).
    req = 4'b1110; tick();
    frame = 1'b0; tick();
    frame = 1'b1; tick();
    chk("b2b_state", arb_state, S_GRANT);
    chk("b2b_gnt",   gnt, 4'b1110);

    // frame low beats req release in GRANT.
    req = 4'b1111; frame = 1'b0; tick();
    chk("prio_busy", arb_state, S_BUSY);
    frame = 1'b1; tick();
    chk("prio_dead", arb_state, S_DEAD);
    tick();
    chk("prio_idle", arb_state, S_IDLE);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
